fwd_regfile: RTL and testbench



---
 rtl/regfile_pkg.sv | 25 ++
 rtl/fwd_regfile_array.sv | 46 ++++
 rtl/fwd_regfile.sv | 117 +++++++++++
 tb/tb_fwd_regfile.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the forwarding register file.
//   XLEN_DEFAULT / NREGS_DEFAULT : default data width and register count
//   reg_addr_t                   : register address type for the default size
//   popcount                     : population count used by consistency checks
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    // Widest pending vector popcount accepts; narrower vectors are zero-extended.
    localparam int unsigned POPCOUNT_W    = 1024;

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [POPCOUNT_W-1:0] v);
        int unsigned c = 0;
        for (int unsigned i = 0; i < POPCOUNT_W; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/fwd_regfile_array.sv
// Register storage with one write port and NRD raw (unbypassed) read ports.
//   clk, rst_n : clock, asynchronous active-low reset (clears every entry)
//   wb_en      : write enable (caller already excludes register 0)
//   wb_addr    : write address
//   wb_data    : write data
//   rd_addr    : packed read addresses, port i at [i*AW +: AW]
//   rd_raw     : packed raw read data, port i at [i*XLEN +: XLEN]
module fwd_regfile_array
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_raw
);

    logic [XLEN-1:0] mem [NREGS];

    // Storage update; reset clears all entries immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else if (wb_en) begin
            mem[wb_addr] <= wb_data;
        end
    end

    // Raw combinational read ports.
    always_comb begin
        rd_raw = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_raw[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/fwd_regfile.sv
// Decode-stage register file with writeback bypass, hardwired-zero r0 and a
// pending-write scoreboard for the hazard unit.
//   clk, rst_n           : clock, asynchronous active-low reset
//   rd_addr / rd_data    : NRD combinational read ports (packed per port)
//   rd_busy              : per-port "register has an unresolved pending write"
//   iss_valid / iss_addr : destination register of an instruction issuing now
//   wb_valid / wb_addr / wb_data : writeback port
//   flush                : discard every pending mark
//   pend_cnt             : registered count of pending registers
module fwd_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [AW:0]         pend_cnt
);

    localparam int unsigned CW = AW + 1;

    logic                wb_en;
    logic [NRD*XLEN-1:0] rd_raw;
    logic [NREGS-1:0]    pend;
    logic [NREGS-1:0]    pend_nxt;
    logic [CW-1:0]       cnt_nxt;
    logic                cnt_inc;
    logic                cnt_dec;

    assign wb_en = wb_valid && (wb_addr != '0);

    fwd_regfile_array #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rd_addr (rd_addr),
        .rd_raw  (rd_raw)
    );

    // Scoreboard next state: flush beats issue, issue beats writeback.
    // The counter tracks the same transitions so it always equals popcount(pend).
    always_comb begin
        pend_nxt = pend;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        if (flush) begin
            pend_nxt = '0;
        end else begin
            if (wb_valid) begin
                pend_nxt[wb_addr] = 1'b0;
            end
            if (iss_valid) begin
                pend_nxt[iss_addr] = 1'b1;
            end
            pend_nxt[0] = 1'b0;
            cnt_inc = iss_valid && (iss_addr != '0) && !pend[iss_addr];
            // A same-address issue keeps the bit set, so the writeback clears nothing.
            cnt_dec = wb_valid && (wb_addr != '0) && pend[wb_addr]
                      && !(iss_valid && (iss_addr == wb_addr));
        end
        cnt_nxt = flush ? '0 : (pend_cnt + CW'(cnt_inc) - CW'(cnt_dec));
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Read ports: r0 is zero, then writeback bypass, then the array.
    // A same-cycle writeback also resolves the busy indication.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (rd_addr[i*AW +: AW] == '0) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (wb_valid && (wb_addr == rd_addr[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = wb_data;
            end else begin
                rd_data[i*XLEN +: XLEN] = rd_raw[i*XLEN +: XLEN];
            end
            rd_busy[i] = pend[rd_addr[i*AW +: AW]]
                         && !(wb_valid && (wb_addr == rd_addr[i*AW +: AW]));
        end
    end

    pend_cnt_consistent: assert property (
        @(posedge clk) disable iff (!rst_n)
        32'(pend_cnt) == popcount(POPCOUNT_W'(pend))
    );

endmodule

// File: tb/tb_fwd_regfile.sv
// Directed scoreboard bench for fwd_regfile (default sizes, two read ports).
module tb_fwd_regfile;
    import regfile_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                wb_valid;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [AW:0]         pend_cnt;

    fwd_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected observation: kind 0 = rd_data, 1 = rd_busy, 2 = pend_cnt.
    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Independent pending-set model, updated from the inputs seen at each edge.
    logic [NREGS-1:0] mp = '0;

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            mp = '0;
        end else begin
            if (wb_valid) mp[wb_addr] = 1'b0;
            if (iss_valid) mp[iss_addr] = 1'b1;
            mp[0] = 1'b0;
        end
    end

    // Monitor: each mid-cycle, check the count invariant and pop this cycle's expectations.
    always @(negedge clk) begin
        logic [31:0] act;
        exp_t e;
        if (!rst_n) mp = '0;
        n_vec++;
        if (32'(pend_cnt) != 32'($countones(mp))) begin
            n_err++;
            $display("FAIL cnt_vs_popcount cyc=%0d got=%0d want=%0d", cyc, pend_cnt, $countones(mp));
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                0:       act = rd_data[e.port*XLEN +: XLEN];
                1:       act = 32'(rd_busy[e.port]);
                default: act = 32'(pend_cnt);
            endcase
            n_vec++;
            if (e.cyc != cyc || act !== e.val) begin
                n_err++;
                $display("FAIL %s cyc=%0d port=%0d got=%h want=%h", e.name, cyc, e.port, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wb_valid  = 1'b0;
        iss_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = AW'(a);
        wb_data  = d;
    endtask

    task automatic iss(input int a);
        iss_valid = 1'b1;
        iss_addr  = AW'(a);
    endtask

    task automatic ed(input int p, input logic [31:0] v, input string n);
        exp_t e;
        e = '{cyc: cyc, kind: 0, port: p, val: v, name: n};
        sb.push_back(e);
    endtask

    task automatic eb(input int p, input logic v, input string n);
        exp_t e;
        e = '{cyc: cyc, kind: 1, port: p, val: 32'(v), name: n};
        sb.push_back(e);
    endtask

    task automatic ec(input int v, input string n);
        exp_t e;
        e = '{cyc: cyc, kind: 2, port: 0, val: 32'(v), name: n};
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_addr = '0; wb_valid = 1'b0;
        wb_addr = '0; wb_data = '0; flush = 1'b0; rd(0, 5);

        // Reset values on ports at addresses 0, 5, 31.
        step(); rd(0, 5);
        ed(0, 32'h0, "rst_d0"); ed(1, 32'h0, "rst_d5");
        eb(0, 1'b0, "rst_b0"); eb(1, 1'b0, "rst_b5"); ec(0, "rst_cnt");
        step(); rd(31, 5);
        ed(0, 32'h0, "rst_d31");
        step(); rst_n = 1'b1; rd(0, 31);
        ed(0, 32'h0, "post_rst_d0"); ed(1, 32'h0, "post_rst_d31"); eb(1, 1'b0, "post_rst_b31"); ec(0, "post_rst_cnt");

        // Write with same-cycle bypass, then through the array; r0 stays zero.
        step(); wb(7, 32'hDEADBEEF); rd(7, 0);
        ed(0, 32'hDEADBEEF, "wb_bypass"); ed(1, 32'h0, "r0_zero");
        step(); rd(7, 0);
        ed(0, 32'hDEADBEEF, "wb_array");
        step(); wb(0, 32'h12345678); rd(0, 7);
        ed(0, 32'h0, "wb0_bypass_zero"); ed(1, 32'hDEADBEEF, "wb_array2");
        step(); rd(0, 7);
        ed(0, 32'h0, "wb0_ignored");

        // Issue r3, resolve it with a writeback four cycles later.
        step(); iss(3); rd(3, 0);
        eb(0, 1'b0, "iss_same_cycle"); ec(0, "iss_cnt0");
        step(); rd(3, 0);
        eb(0, 1'b1, "iss_busy_n1"); ec(1, "iss_cnt_n1");
        step(); eb(0, 1'b1, "iss_busy_n2");
        step(); eb(0, 1'b1, "iss_busy_n3");
        step(); wb(3, 32'h33); rd(3, 0);
        eb(0, 1'b0, "wb_resolve_busy"); ed(0, 32'h33, "wb_resolve_data"); ec(1, "wb_resolve_cnt");
        step(); rd(3, 0);
        eb(0, 1'b0, "after_wb_busy"); ec(0, "after_wb_cnt"); ed(0, 32'h33, "after_wb_data");

        // WAW on r9 with a same-cycle writeback, then net-zero count update.
        step(); iss(9); rd(0, 9);
        ec(0, "waw_cnt0");
        step(); iss(9); wb(9, 32'h99); rd(0, 9);
        eb(1, 1'b0, "waw_wb_busy"); ed(1, 32'h99, "waw_wb_data"); ec(1, "waw_cnt1");
        step(); rd(4, 9);
        eb(1, 1'b1, "waw_keep_busy"); ec(1, "waw_keep_cnt"); ed(1, 32'h99, "waw_data");
        step(); iss(4); wb(9, 32'h999); rd(4, 9);
        ec(1, "net0_pre"); eb(0, 1'b0, "iss4_not_yet"); eb(1, 1'b0, "wb9_resolves");
        step(); wb(4, 32'h44); rd(4, 9);
        ec(1, "net0_cnt"); eb(0, 1'b0, "wb4_bypass_busy"); ed(0, 32'h44, "wb4_data"); eb(1, 1'b0, "p9_clear");
        step(); rd(4, 9);
        ec(0, "net0_drain"); ed(1, 32'h999, "r9_data");

        // Three issues, then flush together with an issue and a writeback.
        step(); iss(1); rd(1, 2); ec(0, "fl_cnt0");
        step(); iss(2); ec(1, "fl_cnt1");
        step(); iss(3); rd(1, 2);
        ec(2, "fl_cnt2"); eb(0, 1'b1, "fl_busy1"); eb(1, 1'b1, "fl_busy2");
        step(); flush = 1'b1; iss(5); wb(2, 32'h55); rd(2, 5);
        ec(3, "fl_cnt3"); ed(0, 32'h55, "fl_wb_bypass"); eb(0, 1'b0, "fl_b2"); eb(1, 1'b0, "fl_b5");
        step(); rd(2, 5);
        ec(0, "fl_cnt_clr"); ed(0, 32'h55, "fl_wb_kept"); eb(0, 1'b0, "fl_b2_after"); eb(1, 1'b0, "fl_iss_ignored");
        step(); rd(1, 3);
        eb(0, 1'b0, "fl_b1_after"); eb(1, 1'b0, "fl_b3_after"); ec(0, "fl_cnt_hold");

        // Asynchronous reset between edges, writeback blocked while in reset.
        step(); iss(6); wb(10, 32'hA0A0A0A0); rd(6, 10);
        ec(0, "ar_cnt0"); ed(1, 32'hA0A0A0A0, "ar_bypass"); eb(0, 1'b0, "ar_b6_pre");
        step(); rd(6, 10);
        eb(0, 1'b1, "ar_b6"); ec(1, "ar_cnt1"); ed(1, 32'hA0A0A0A0, "ar_d10");
        step(); #2; rst_n = 1'b0;
        ed(1, 32'h0, "ar_d10_clr"); eb(0, 1'b0, "ar_b6_clr"); ec(0, "ar_cnt_clr");
        step(); wb(10, 32'hFF); rd(6, 10);
        ed(1, 32'hFF, "ar_rst_bypass"); ec(0, "ar_rst_cnt");
        step(); rd(6, 10);
        ed(1, 32'h0, "ar_no_write");
        step(); rst_n = 1'b1; rd(6, 10);
        ed(1, 32'h0, "ar_rel_d10"); eb(0, 1'b0, "ar_rel_b6"); ec(0, "ar_rel_cnt");
        step(); ed(1, 32'h0, "ar_final_d10"); ec(0, "ar_final_cnt");

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
